wb_reg_bank_gen2: RTL and testbench
===================================

Name: wb_reg_bank_gen2

Overview:
- Parametrised Wishbone slave register bank for the AL4S3B FPGA fabric, sitting behind the AHB-to-FPGA bridge.
- Successor to the fixed ID/revision register block. Adds:
  - configurable ACK wait states;
  - N byte-strobed scratch/control registers;
  - sticky event status with write-1-to-clear and a masked interrupt;
  - a 64-bit free-running timestamp with atomic high-word snapshot.

Parameters:
- ADDRWIDTH, 10, byte address width; word index = WBs_ADR_i[ADDRWIDTH-1:2].
- DATAWIDTH, 32, data bus width; fixed at 32, other values unsupported.
- NUM_RW_REGS, 4, number of scratch registers (1..16).
- NUM_EVT, 8, number of event inputs (1..32).
- ACK_WAIT, 0, wait cycles inserted before ACK (0..7).
- DEVICE_ID, 32'hABCD0002, value of the ID register.
- REV_LEVEL, 32'h00000200, value of the REV register.
- SCRATCH_RESET, 32'h12345678, reset value of every scratch register.
- DEF_REG_VALUE, 32'hFABDEFAC, read value of any unmapped address.

Ports:
- WBs_CLK_i  in  1  single clock for the whole block.
- WBs_RST_i  in  1  synchronous, active-high reset.
- WBs_ADR_i  in  ADDRWIDTH  byte address.
- WBs_CYC_i  in  1  cycle / chip select.
- WBs_STB_i  in  1  transfer strobe.
- WBs_WE_i  in  1  write enable.
- WBs_BYTE_STB_i  in  4  byte enables.
- WBs_DAT_i  in  32  write data.
- WBs_DAT_o  out  32  registered read data.
- WBs_ACK_o  out  1  one-cycle acknowledge.
- evt_i  in  NUM_EVT  event inputs; level high sets the sticky status bit.
- int_o  out  1  registered interrupt = |(STATUS & INT_EN).

Behaviour:
- Clocking and reset:
  - One clock (WBs_CLK_i). Reset is synchronous and active-high (WBs_RST_i sampled on the rising edge).
  - Reset values: WBs_ACK_o=0, WBs_DAT_o=0, int_o=0, STATUS=0, INT_EN=0, timestamp=0, TS_HI snapshot=0, wait counter=0, every scratch register=SCRATCH_RESET.
- Address map (byte offsets):
  - 0x000 ID (RO)
  - 0x004 REV (RO)
  - 0x008 STATUS (W1C; NUM_EVT LSBs, upper bits read 0)
  - 0x00C INT_EN (RW; NUM_EVT LSBs)
  - 0x010 TS_LO (RO)
  - 0x014 TS_HI_SNAP (RO)
  - 0x040+4k SCRATCH[k], k<NUM_RW_REGS
  - All other addresses read DEF_REG_VALUE; writes to them are ignored.
- Handshake:
  - req = WBs_CYC_i & WBs_STB_i & ~WBs_ACK_o.
  - Wait counter increments while req is high and clears when req is low.
  - WBs_ACK_o asserts for exactly 1 cycle on the edge after req has been high for ACK_WAIT+1 consecutive cycles (ACK_WAIT=0 gives the next-cycle ACK).
  - ACK then deasserts for at least 1 cycle, so back-to-back transfers each take ACK_WAIT+2 cycles.
  - If CYC or STB drops before ACK: counter clears, no ACK, no register side effect.
- Write commit:
  - Commits on the same edge that sets ACK, using the address/data/strobes sampled on that edge.
  - Per byte lane: byte i is written only if WBs_BYTE_STB_i[i]. Applies to SCRATCH and INT_EN.
  - STATUS: bit j clears when data bit j = 1 and its byte lane is enabled.
- Read data:
  - WBs_DAT_o loads the addressed value on the edge that sets ACK and holds until the next load.
- Timestamp snapshot:
  - 64-bit counter increments every cycle and wraps from 2^64-1 to 0.
  - A read of TS_LO returns the counter low word and, on the same edge, captures the high word into TS_HI_SNAP. A later TS_HI_SNAP read is therefore coherent.
- Events and interrupt:
  - STATUS[j] <= (STATUS[j] & ~clr[j]) | evt_i[j]. If set and clear happen in the same cycle, set wins.
  - int_o registered: 1 cycle after the STATUS/INT_EN change.
- Mid-operation reset: a reset pending during a wait aborts the transfer (no ACK, no write). The master must re-issue.

Decomposition:
- Package wb_reg_bank_pkg holds:
  - address offset localparams: ADR_ID, ADR_REV, ADR_STATUS, ADR_INT_EN, ADR_TS_LO, ADR_TS_HI, ADR_SCRATCH_BASE;
  - the byte-lane write-merge function.
- One sub-module, wb_ack_waitgen: req-to-ACK wait counter, parametrised by ACK_WAIT, outputs ack and commit strobe. Registers stay in the top.

Test Plan:
- Post-reset read sweep:
  - 0x000 -> 0xABCD0002; 0x004 -> 0x00000200; 0x040 -> 0x12345678; 0x3FC -> 0xFABDEFAC.
  - With ACK_WAIT=0, ACK arrives exactly 1 cycle after STB.
- Byte-lane write, then read back:
  - Write 0xAABBCCDD to 0x044 with BYTE_STB=4'b0101 -> read returns 0x12BB56DD.
- Wait states and abort:
  - ACK_WAIT=3: ACK arrives on cycle 4 after STB.
  - Drop STB after 2 cycles -> no ACK and SCRATCH unchanged.
- Events and interrupt:
  - Write INT_EN=0x01, pulse evt_i[0] -> STATUS=0x01 and int_o=1 one cycle later.
  - Write 0x01 to STATUS -> int_o=0.
  - evt_i[0] held high during the W1C write -> bit stays 1.
- Timestamp coherence:
  - Force the counter to 0x00000000_FFFFFFFE, read TS_LO, then TS_HI_SNAP -> 0x00000000. TS_HI_SNAP stays 0 after the low word wraps.
  - At 2^64-1 the counter wraps to 0.
- Reset mid-transfer:
  - Assert WBs_RST_i during an ACK_WAIT=3 write -> no ACK, scratch = 0x12345678, int_o=0.

Source files
------------

// File: rtl/wb_reg_bank_pkg.sv
// wb_reg_bank_pkg
//   Shared definitions for the gen2 Wishbone register bank:
//   byte offsets of the register map and the byte-lane write helpers.
package wb_reg_bank_pkg;

  localparam logic [11:0] ADR_ID           = 12'h000;
  localparam logic [11:0] ADR_REV          = 12'h004;
  localparam logic [11:0] ADR_STATUS       = 12'h008;
  localparam logic [11:0] ADR_INT_EN       = 12'h00C;
  localparam logic [11:0] ADR_TS_LO        = 12'h010;
  localparam logic [11:0] ADR_TS_HI        = 12'h014;
  localparam logic [11:0] ADR_SCRATCH_BASE = 12'h040;

  // Expand 4 byte enables into a 32-bit bit mask.
  function automatic logic [31:0] be_mask(input logic [3:0] be);
    logic [31:0] m;
    m = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      m[8*i +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

  // Replace only the enabled byte lanes of old_val with new_val.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
    logic [31:0] m;
    m = be_mask(be);
    return (old_val & ~m) | (new_val & m);
  endfunction

endpackage

// File: rtl/wb_ack_waitgen.sv
// wb_ack_waitgen
//   Turns a Wishbone request into a one-cycle ACK after ACK_WAIT+1
//   consecutive request cycles.
//   Ports:
//     WBs_CLK_i, WBs_RST_i : clock, synchronous active-high reset
//     cyc, stb             : Wishbone cycle / strobe
//     ack                  : registered one-cycle acknowledge
//     commit               : high in the cycle whose rising edge sets ack
module wb_ack_waitgen #(
  parameter int unsigned ACK_WAIT = 0
) (
  input  logic WBs_CLK_i,
  input  logic WBs_RST_i,
  input  logic cyc,
  input  logic stb,
  output logic ack,
  output logic commit
);

  logic [2:0] wait_cnt;
  logic       req;
  logic       done;

  // Masking with ack forces at least one idle cycle between transfers.
  assign req    = cyc & stb & ~ack;
  assign done   = req && (wait_cnt == 3'(ACK_WAIT));
  assign commit = done & ~WBs_RST_i;

  always_ff @(posedge WBs_CLK_i) begin
    if (WBs_RST_i) begin
      ack      <= 1'b0;
      wait_cnt <= '0;
    end else begin
      ack <= done;
      if (req && !done) begin
        wait_cnt <= wait_cnt + 3'd1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/wb_reg_bank_gen2.sv
// wb_reg_bank_gen2
//   Wishbone slave register bank: ID/REV, sticky W1C event status with
//   masked interrupt, 64-bit timestamp with high-word snapshot, and
//   NUM_RW_REGS byte-strobed scratch registers.
//   Ports:
//     WBs_CLK_i, WBs_RST_i        : clock, synchronous active-high reset
//     WBs_ADR_i/CYC/STB/WE/BYTE_STB/DAT_i : Wishbone slave inputs
//     WBs_DAT_o, WBs_ACK_o        : registered read data, one-cycle ACK
//     evt_i                       : level event inputs (set STATUS bits)
//     int_o                       : registered |(STATUS & INT_EN)
module wb_reg_bank_gen2
  import wb_reg_bank_pkg::*;
#(
  parameter int unsigned ADDRWIDTH     = 10,
  parameter int unsigned DATAWIDTH     = 32,
  parameter int unsigned NUM_RW_REGS   = 4,
  parameter int unsigned NUM_EVT       = 8,
  parameter int unsigned ACK_WAIT      = 0,
  parameter logic [31:0] DEVICE_ID     = 32'hABCD0002,
  parameter logic [31:0] REV_LEVEL     = 32'h00000200,
  parameter logic [31:0] SCRATCH_RESET = 32'h12345678,
  parameter logic [31:0] DEF_REG_VALUE = 32'hFABDEFAC
) (
  input  logic                 WBs_CLK_i,
  input  logic                 WBs_RST_i,
  input  logic [ADDRWIDTH-1:0] WBs_ADR_i,
  input  logic                 WBs_CYC_i,
  input  logic                 WBs_STB_i,
  input  logic                 WBs_WE_i,
  input  logic [3:0]           WBs_BYTE_STB_i,
  input  logic [DATAWIDTH-1:0] WBs_DAT_i,
  output logic [DATAWIDTH-1:0] WBs_DAT_o,
  output logic                 WBs_ACK_o,
  input  logic [NUM_EVT-1:0]   evt_i,
  output logic                 int_o
);

  localparam int unsigned AW = ADDRWIDTH - 2;
  localparam logic [AW-1:0] W_ID     = AW'(ADR_ID     >> 2);
  localparam logic [AW-1:0] W_REV    = AW'(ADR_REV    >> 2);
  localparam logic [AW-1:0] W_STATUS = AW'(ADR_STATUS >> 2);
  localparam logic [AW-1:0] W_INT_EN = AW'(ADR_INT_EN >> 2);
  localparam logic [AW-1:0] W_TS_LO  = AW'(ADR_TS_LO  >> 2);
  localparam logic [AW-1:0] W_TS_HI  = AW'(ADR_TS_HI  >> 2);
  localparam logic [31:0]   SCR_WORD = 32'(ADR_SCRATCH_BASE) >> 2;

  logic [AW-1:0]      adr_word;
  logic [31:0]        scr_off;
  logic               commit;
  logic [31:0]        rd_data;
  logic [NUM_EVT-1:0] status;
  logic [NUM_EVT-1:0] int_en;
  logic [NUM_EVT-1:0] status_clr;
  logic [63:0]        ts_cnt;
  logic [31:0]        ts_hi_snap;
  logic [31:0]        scratch [NUM_RW_REGS];
  logic               unused_adr_lsb;

  assign adr_word       = WBs_ADR_i[ADDRWIDTH-1:2];
  assign unused_adr_lsb = ^WBs_ADR_i[1:0];
  // Addresses below the scratch base wrap to huge offsets and never match.
  assign scr_off        = 32'(adr_word) - SCR_WORD;

  wb_ack_waitgen #(
    .ACK_WAIT (ACK_WAIT)
  ) u_waitgen (
    .WBs_CLK_i (WBs_CLK_i),
    .WBs_RST_i (WBs_RST_i),
    .cyc       (WBs_CYC_i),
    .stb       (WBs_STB_i),
    .ack       (WBs_ACK_o),
    .commit    (commit)
  );

  always_comb begin
    rd_data = DEF_REG_VALUE;
    case (adr_word)
      W_ID:     rd_data = DEVICE_ID;
      W_REV:    rd_data = REV_LEVEL;
      W_STATUS: rd_data = 32'(status);
      W_INT_EN: rd_data = 32'(int_en);
      W_TS_LO:  rd_data = ts_cnt[31:0];
      W_TS_HI:  rd_data = ts_hi_snap;
      default:  rd_data = DEF_REG_VALUE;
    endcase
    for (int unsigned k = 0; k < NUM_RW_REGS; k++) begin
      if (scr_off == k) rd_data = scratch[k];
    end
  end

  always_comb begin
    status_clr = '0;
    if (commit && WBs_WE_i && adr_word == W_STATUS) begin
      status_clr = NUM_EVT'(WBs_DAT_i & be_mask(WBs_BYTE_STB_i));
    end
  end

  always_ff @(posedge WBs_CLK_i) begin
    if (WBs_RST_i) begin
      WBs_DAT_o  <= '0;
      int_o      <= 1'b0;
      status     <= '0;
      int_en     <= '0;
      ts_cnt     <= '0;
      ts_hi_snap <= '0;
      for (int unsigned k = 0; k < NUM_RW_REGS; k++) begin
        scratch[k] <= SCRATCH_RESET;
      end
    end else begin
      ts_cnt <= ts_cnt + 64'd1;
      // Set wins over a simultaneous write-1-to-clear.
      status <= (status & ~status_clr) | evt_i;
      int_o  <= |(status & int_en);
      if (commit) begin
        WBs_DAT_o <= rd_data;
        // Snapshot high word together with the low-word read for coherence.
        if (!WBs_WE_i && adr_word == W_TS_LO) begin
          ts_hi_snap <= ts_cnt[63:32];
        end
        if (WBs_WE_i) begin
          if (adr_word == W_INT_EN) begin
            int_en <= NUM_EVT'(byte_merge(32'(int_en), WBs_DAT_i, WBs_BYTE_STB_i));
          end
          for (int unsigned k = 0; k < NUM_RW_REGS; k++) begin
            if (scr_off == k) begin
              scratch[k] <= byte_merge(scratch[k], WBs_DAT_i, WBs_BYTE_STB_i);
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_reg_bank_gen2.sv
module tb_wb_reg_bank_gen2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  adr = '0;
  logic        cyc0 = 1'b0;
  logic        cyc3 = 1'b0;
  logic        stb = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  be = '0;
  logic [31:0] wdat = '0;
  logic [7:0]  evt = '0;
  logic [31:0] dat0, dat3;
  logic        ack0, ack3, int0, int3;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  wb_reg_bank_gen2 #(.ACK_WAIT(0)) dut0 (
    .WBs_CLK_i(clk), .WBs_RST_i(rst), .WBs_ADR_i(adr), .WBs_CYC_i(cyc0),
    .WBs_STB_i(stb), .WBs_WE_i(we), .WBs_BYTE_STB_i(be), .WBs_DAT_i(wdat),
    .WBs_DAT_o(dat0), .WBs_ACK_o(ack0), .evt_i(evt), .int_o(int0)
  );

  wb_reg_bank_gen2 #(.ACK_WAIT(3)) dut3 (
    .WBs_CLK_i(clk), .WBs_RST_i(rst), .WBs_ADR_i(adr), .WBs_CYC_i(cyc3),
    .WBs_STB_i(stb), .WBs_WE_i(we), .WBs_BYTE_STB_i(be), .WBs_DAT_i(wdat),
    .WBs_DAT_o(dat3), .WBs_ACK_o(ack3), .evt_i(evt), .int_o(int3)
  );

  // One bus transfer; lat = negedges from request to observed ACK.
  task automatic xfer(input bit w3, input bit wr, input logic [9:0] a,
                      input logic [3:0] b, input logic [31:0] d,
                      output logic [31:0] rdat, output int lat);
    bit got;
    @(negedge clk);
    adr = a; we = wr; be = b; wdat = d; stb = 1'b1;
    if (w3) cyc3 = 1'b1; else cyc0 = 1'b1;
    got = 1'b0; lat = 0; rdat = '0;
    for (int i = 1; i <= 20 && !got; i++) begin
      @(negedge clk);
      if ((w3 ? ack3 : ack0) === 1'b1) begin
        got = 1'b1; lat = i; rdat = w3 ? dat3 : dat0;
      end
    end
    cyc0 = 1'b0; cyc3 = 1'b0; stb = 1'b0; we = 1'b0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL ack_timeout: addr %h got no ACK, required ACK within 20 cycles", a);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({ack0, ack3} !== 2'b00) begin errors++; $display("FAIL reset_ack: got %b required 00", {ack0, ack3}); end
    checks++;
    if (dat0 !== 32'h0 || dat3 !== 32'h0) begin errors++; $display("FAIL reset_dat: got %h/%h required 0", dat0, dat3); end
    checks++;
    if ({int0, int3} !== 2'b00) begin errors++; $display("FAIL reset_int: got %b required 00", {int0, int3}); end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({ack0, ack3} !== 2'b00) begin errors++; $display("FAIL idle_ack: got %b required 00", {ack0, ack3}); end
  endtask

  task automatic test_read_sweep();
    logic [9:0]  a [9];
    logic [31:0] e [9];
    logic [31:0] r, x;
    int lat;
    a = '{10'h000, 10'h004, 10'h008, 10'h00C, 10'h014, 10'h040, 10'h04C, 10'h050, 10'h3FC};
    e = '{32'hABCD0002, 32'h00000200, 32'h0, 32'h0, 32'h0,
          32'h12345678, 32'h12345678, 32'hFABDEFAC, 32'hFABDEFAC};
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back(e[i]);
      xfer(1'b0, 1'b0, a[i], 4'hF, 32'h0, r, lat);
      x = exp_q.pop_front();
      checks++;
      if (r !== x) begin errors++; $display("FAIL sweep_data@%h: got %h required %h", a[i], r, x); end
      checks++;
      if (lat != 1) begin errors++; $display("FAIL sweep_latency@%h: got %0d required 1", a[i], lat); end
    end
  endtask

  task automatic test_byte_lane();
    logic [31:0] r, x;
    int lat;
    xfer(1'b0, 1'b1, 10'h044, 4'b0101, 32'hAABBCCDD, r, lat);
    xfer(1'b0, 1'b1, 10'h04C, 4'b1111, 32'h0BADF00D, r, lat);
    xfer(1'b0, 1'b1, 10'h000, 4'b1111, 32'h0, r, lat);
    xfer(1'b0, 1'b1, 10'h050, 4'b1111, 32'h0, r, lat);
    exp_q.push_back(32'h12BB56DD); exp_q.push_back(32'h0BADF00D);
    exp_q.push_back(32'h12345678); exp_q.push_back(32'hABCD0002);
    exp_q.push_back(32'hFABDEFAC);
    begin
      logic [9:0] ra [5];
      ra = '{10'h044, 10'h04C, 10'h040, 10'h000, 10'h050};
      for (int i = 0; i < 5; i++) begin
        xfer(1'b0, 1'b0, ra[i], 4'hF, 32'h0, r, lat);
        x = exp_q.pop_front();
        checks++;
        if (r !== x) begin errors++; $display("FAIL byte_lane@%h: got %h required %h", ra[i], r, x); end
      end
    end
  endtask

  task automatic test_wait_abort();
    logic [31:0] r, x;
    int lat, nack;
    exp_q.push_back(32'h12345678);
    xfer(1'b1, 1'b0, 10'h040, 4'hF, 32'h0, r, lat);
    x = exp_q.pop_front();
    checks++;
    if (r !== x) begin errors++; $display("FAIL wait_data: got %h required %h", r, x); end
    checks++;
    if (lat != 4) begin errors++; $display("FAIL wait_latency: got %0d required 4", lat); end
    // Abort after 2 request cycles.
    @(negedge clk);
    adr = 10'h040; we = 1'b1; be = 4'hF; wdat = 32'hDEADBEEF; stb = 1'b1; cyc3 = 1'b1;
    nack = 0;
    repeat (2) begin @(negedge clk); if (ack3 === 1'b1) nack++; end
    stb = 1'b0; cyc3 = 1'b0; we = 1'b0;
    repeat (6) begin @(negedge clk); if (ack3 === 1'b1) nack++; end
    checks++;
    if (nack != 0) begin errors++; $display("FAIL abort_ack: got %0d ACKs required 0", nack); end
    exp_q.push_back(32'h12345678);
    xfer(1'b1, 1'b0, 10'h040, 4'hF, 32'h0, r, lat);
    x = exp_q.pop_front();
    checks++;
    if (r !== x) begin errors++; $display("FAIL abort_scratch: got %h required %h", r, x); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] seen, want;
    seen = '0; want = 16'h4210;  // ACKs at cycles 4, 9, 14
    @(negedge clk);
    adr = 10'h000; we = 1'b0; be = 4'hF; stb = 1'b1; cyc3 = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      seen[i] = (ack3 === 1'b1);
    end
    stb = 1'b0; cyc3 = 1'b0;
    @(negedge clk);
    checks++;
    if (seen !== want) begin errors++; $display("FAIL back_to_back_acks: got %b required %b", seen, want); end
  endtask

  task automatic test_events();
    logic [31:0] r, x;
    int lat;
    xfer(1'b0, 1'b1, 10'h00C, 4'b0001, 32'h00000001, r, lat);
    @(negedge clk); evt = 8'h01;
    @(negedge clk); evt = 8'h00;
    checks++;
    if (int0 !== 1'b0) begin errors++; $display("FAIL int_early: got %b required 0", int0); end
    @(negedge clk);
    checks++;
    if (int0 !== 1'b1) begin errors++; $display("FAIL int_set: got %b required 1", int0); end
    // Masked event sets status only.
    @(negedge clk); evt = 8'h02;
    @(negedge clk); evt = 8'h00;
    exp_q.push_back(32'h00000003);
    xfer(1'b0, 1'b0, 10'h008, 4'hF, 32'h0, r, lat);
    x = exp_q.pop_front();
    checks++;
    if (r !== x) begin errors++; $display("FAIL status_set: got %h required %h", r, x); end
    // W1C with byte lane 0 disabled does nothing.
    xfer(1'b0, 1'b1, 10'h008, 4'b1110, 32'h00000001, r, lat);
    exp_q.push_back(32'h00000003);
    xfer(1'b0, 1'b0, 10'h008, 4'hF, 32'h0, r, lat);
    x = exp_q.pop_front();
    checks++;
    if (r !== x) begin errors++; $display("FAIL w1c_lane_off: got %h required %h", r, x); end
    xfer(1'b0, 1'b1, 10'h008, 4'b0001, 32'h00000003, r, lat);
    checks++;
    if (int0 !== 1'b1) begin errors++; $display("FAIL int_clear_latency: got %b required 1", int0); end
    @(negedge clk);
    checks++;
    if (int0 !== 1'b0) begin errors++; $display("FAIL int_cleared: got %b required 0", int0); end
    // Event held during the clear: set wins.
    @(negedge clk); evt = 8'h01;
    xfer(1'b0, 1'b1, 10'h008, 4'b0001, 32'h00000001, r, lat);
    evt = 8'h00;
    exp_q.push_back(32'h00000001);
    xfer(1'b0, 1'b0, 10'h008, 4'hF, 32'h0, r, lat);
    x = exp_q.pop_front();
    checks++;
    if (r !== x) begin errors++; $display("FAIL set_wins: got %h required %h", r, x); end
    xfer(1'b0, 1'b1, 10'h008, 4'b0001, 32'h00000001, r, lat);
    repeat (2) @(negedge clk);
    checks++;
    if (int0 !== 1'b0) begin errors++; $display("FAIL int_final: got %b required 0", int0); end
  endtask

  task automatic test_timestamp();
    logic [31:0] r, x;
    int lat;
    @(negedge clk);
    force dut0.ts_cnt = 64'h00000000_FFFFFFFE;
    exp_q.push_back(32'hFFFFFFFE);
    xfer(1'b0, 1'b0, 10'h010, 4'hF, 32'h0, r, lat);
    x = exp_q.pop_front();
    checks++;
    if (r !== x) begin errors++; $display("FAIL ts_lo: got %h required %h", r, x); end
    exp_q.push_back(32'h0);
    xfer(1'b0, 1'b0, 10'h014, 4'hF, 32'h0, r, lat);
    x = exp_q.pop_front();
    checks++;
    if (r !== x) begin errors++; $display("FAIL ts_hi_snap: got %h required %h", r, x); end
    release dut0.ts_cnt;
    repeat (8) @(negedge clk);
    exp_q.push_back(32'h0);
    xfer(1'b0, 1'b0, 10'h014, 4'hF, 32'h0, r, lat);
    x = exp_q.pop_front();
    checks++;
    if (r !== x) begin errors++; $display("FAIL ts_hi_after_wrap: got %h required %h", r, x); end
    xfer(1'b0, 1'b0, 10'h010, 4'hF, 32'h0, r, lat);
    checks++;
    if (!(r < 32'h100)) begin errors++; $display("FAIL ts_lo_wrapped: got %h required below 00000100", r); end
    exp_q.push_back(32'h1);
    xfer(1'b0, 1'b0, 10'h014, 4'hF, 32'h0, r, lat);
    x = exp_q.pop_front();
    checks++;
    if (r !== x) begin errors++; $display("FAIL ts_hi_carry: got %h required %h", r, x); end
    // Full 64-bit wrap.
    @(negedge clk);
    force dut0.ts_cnt = 64'hFFFFFFFF_FFFFFFF8;
    @(negedge clk);
    release dut0.ts_cnt;
    repeat (20) @(negedge clk);
    xfer(1'b0, 1'b0, 10'h010, 4'hF, 32'h0, r, lat);
    checks++;
    if (!(r < 32'h100)) begin errors++; $display("FAIL ts64_wrap_lo: got %h required below 00000100", r); end
    exp_q.push_back(32'h0);
    xfer(1'b0, 1'b0, 10'h014, 4'hF, 32'h0, r, lat);
    x = exp_q.pop_front();
    checks++;
    if (r !== x) begin errors++; $display("FAIL ts64_wrap_hi: got %h required %h", r, x); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r, x;
    int lat, nack;
    xfer(1'b1, 1'b1, 10'h00C, 4'b0001, 32'h00000001, r, lat);
    @(negedge clk); evt = 8'h01;
    @(negedge clk); evt = 8'h00;
    @(negedge clk);
    checks++;
    if (int3 !== 1'b1) begin errors++; $display("FAIL mid_int_pre: got %b required 1", int3); end
    @(negedge clk);
    adr = 10'h040; we = 1'b1; be = 4'hF; wdat = 32'hDEADBEEF; stb = 1'b1; cyc3 = 1'b1;
    nack = 0;
    repeat (2) begin @(negedge clk); if (ack3 === 1'b1) nack++; end
    rst = 1'b1;
    @(negedge clk); if (ack3 === 1'b1) nack++;
    rst = 1'b0; stb = 1'b0; cyc3 = 1'b0; we = 1'b0;
    repeat (5) begin @(negedge clk); if (ack3 === 1'b1) nack++; end
    checks++;
    if (nack != 0) begin errors++; $display("FAIL mid_reset_ack: got %0d ACKs required 0", nack); end
    checks++;
    if (int3 !== 1'b0) begin errors++; $display("FAIL mid_reset_int: got %b required 0", int3); end
    exp_q.push_back(32'h12345678);
    xfer(1'b1, 1'b0, 10'h040, 4'hF, 32'h0, r, lat);
    x = exp_q.pop_front();
    checks++;
    if (r !== x) begin errors++; $display("FAIL mid_reset_scratch: got %h required %h", r, x); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_read_sweep();
    test_byte_lane();
    test_wait_abort();
    test_back_to_back();
    test_events();
    test_timestamp();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
